// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Two-master, one-slave round-robin bus arbiter with an optional
//   transaction timeout.
//
//   Ports
//     clk, rst_n                    clock, asynchronous active-low reset
//     m0_* / m1_*  (in)             addr, wdata, wmask, wen, ren of each master
//     m0_rdata / m1_rdata  (out)    read data back to each master
//     m0_done / m1_done    (out)    one-cycle completion pulse per master
//     s_addr..s_ren        (out)    shared slave request (mirror of the owner)
//     s_rdata, s_done      (in)     slave response
//     grant                (out)    one-hot owner, 2'b00 when idle; this is
//                                   the FSM state itself
//     timeout_err          (out)    sticky: some transaction was aborted
//     err_master           (out)    owner of the most recent aborted transaction
//
//   Handshake: a master requests by holding ren and/or wen high until it sees
//   its done pulse. The slave completes by raising s_done for one cycle while
//   s_ren or s_wen is high; s_done seen while idle is ignored. There is always
//   one idle cycle between consecutive grants.
module bus_arbiter #(
  parameter int unsigned TIMEOUT    = 0,
  parameter logic [31:0] ABORT_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  input  logic        m0_wen,
  input  logic        m0_ren,
  output logic [31:0] m0_rdata,
  output logic        m0_done,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  input  logic        m1_wen,
  input  logic        m1_ren,
  output logic [31:0] m1_rdata,
  output logic        m1_done,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wmask,
  output logic        s_wen,
  output logic        s_ren,
  input  logic [31:0] s_rdata,
  input  logic        s_done,
  output logic [1:0]  grant,
  output logic        timeout_err,
  output logic        err_master
);

  // Encoding equals the grant vector so grant is a direct view of the state.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  localparam bit          TO_EN   = (TIMEOUT != 0);
  localparam logic [15:0] TO_LAST = TO_EN ? 16'(TIMEOUT - 1) : 16'd0;

  state_t      state;
  logic        last_gnt;   // master granted most recently; 1 after reset
  logic [15:0] cnt;        // GNT cycles elapsed without s_done

  logic req0, req1, granted, sel1, req_sel, fin, abort;

  assign req0    = m0_ren | m0_wen;
  assign req1    = m1_ren | m1_wen;
  assign granted = (state == GNT0) || (state == GNT1);
  assign sel1    = (state == GNT1);
  assign req_sel = sel1 ? req1 : req0;

  // A dropped request masks s_done: the slave sees no ren/wen then.
  assign fin   = granted && req_sel && s_done;
  assign abort = granted && req_sel && !s_done && TO_EN && (cnt == TO_LAST);

  assign grant = state;

  always_comb begin
    s_addr  = 32'd0;
    s_wdata = 32'd0;
    s_wmask = 4'd0;
    s_wen   = 1'b0;
    s_ren   = 1'b0;
    case (state)
      GNT0: begin
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
        s_wmask = m0_wmask;
        s_wen   = m0_wen;
        s_ren   = m0_ren;
      end
      GNT1: begin
        s_addr  = m1_addr;
        s_wdata = m1_wdata;
        s_wmask = m1_wmask;
        s_wen   = m1_wen;
        s_ren   = m1_ren;
      end
      default: ;
    endcase
  end

  assign m0_done  = (state == GNT0) && (fin || abort);
  assign m1_done  = (state == GNT1) && (fin || abort);
  assign m0_rdata = ((state == GNT0) && abort) ? ABORT_DATA : s_rdata;
  assign m1_rdata = ((state == GNT1) && abort) ? ABORT_DATA : s_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_gnt    <= 1'b1;
      cnt         <= 16'd0;
      timeout_err <= 1'b0;
      err_master  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= 16'd0;
          if (req0 && req1) state <= last_gnt ? GNT0 : GNT1;
          else if (req0)    state <= GNT0;
          else if (req1)    state <= GNT1;
        end
        default: begin
          if (!req_sel || fin || abort) begin
            state    <= IDLE;
            last_gnt <= sel1;
            if (abort) begin
              timeout_err <= 1'b1;
              err_master  <= sel1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter
//   Directed bench for bus_arbiter (TIMEOUT=4). A behavioural model tracks
//   the owner, the number of cycles it has waited and the round-robin winner,
//   and every falling edge all outputs are compared against it. Directed
//   scenarios add hand-computed literal checks.
module tb_bus_arbiter;

  localparam int          TO    = 4;
  localparam logic [31:0] ABORT = 32'hDEADBEEF;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic [3:0]  m0_wmask = '0, m1_wmask = '0;
  logic        m0_wen = 1'b0, m0_ren = 1'b0, m1_wen = 1'b0, m1_ren = 1'b0;
  logic [31:0] s_rdata = '0;
  logic        s_done  = 1'b0;

  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic        m0_done, m1_done, s_wen, s_ren, timeout_err, err_master;
  logic [3:0]  s_wmask;
  logic [1:0]  grant;

  bus_arbiter #(.TIMEOUT(TO), .ABORT_DATA(ABORT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
    .m0_wen(m0_wen), .m0_ren(m0_ren), .m0_rdata(m0_rdata), .m0_done(m0_done),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
    .m1_wen(m1_wen), .m1_ren(m1_ren), .m1_rdata(m1_rdata), .m1_done(m1_done),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wmask(s_wmask),
    .s_wen(s_wen), .s_ren(s_ren), .s_rdata(s_rdata), .s_done(s_done),
    .grant(grant), .timeout_err(timeout_err), .err_master(err_master)
  );

  // ---------------- scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int mdl_owner   = -1;  // -1 idle, else master index
  int mdl_wait    = 0;   // GNT cycles so far, current one included
  bit mdl_last    = 1'b1;
  bit mdl_err     = 1'b0;
  bit mdl_err_idx = 1'b0;

  always @(negedge clk) begin
    logic        r0, r1, rq, fin, abrt;
    logic [1:0]  e_grant;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wmask;
    logic        e_wen, e_ren;
    if (!rst_n) begin
      mdl_owner = -1; mdl_wait = 0; mdl_last = 1'b1;
      mdl_err = 1'b0; mdl_err_idx = 1'b0;
    end
    r0   = m0_ren | m0_wen;
    r1   = m1_ren | m1_wen;
    rq   = (mdl_owner == 0) ? r0 : (mdl_owner == 1) ? r1 : 1'b0;
    fin  = rq && s_done;
    abrt = rq && !s_done && (mdl_wait == TO);
    e_grant = 2'b00; e_addr = '0; e_wdata = '0; e_wmask = '0; e_wen = 0; e_ren = 0;
    if (mdl_owner == 0) begin
      e_grant = 2'b01; e_addr = m0_addr; e_wdata = m0_wdata; e_wmask = m0_wmask;
      e_wen = m0_wen; e_ren = m0_ren;
    end else if (mdl_owner == 1) begin
      e_grant = 2'b10; e_addr = m1_addr; e_wdata = m1_wdata; e_wmask = m1_wmask;
      e_wen = m1_wen; e_ren = m1_ren;
    end
    check("mdl_grant",   32'(grant),   32'(e_grant));
    check("mdl_s_addr",  s_addr,       e_addr);
    check("mdl_s_wdata", s_wdata,      e_wdata);
    check("mdl_s_wmask", 32'(s_wmask), 32'(e_wmask));
    check("mdl_s_wen",   32'(s_wen),   32'(e_wen));
    check("mdl_s_ren",   32'(s_ren),   32'(e_ren));
    check("mdl_m0_done", 32'(m0_done), 32'((mdl_owner == 0) && (fin || abrt)));
    check("mdl_m1_done", 32'(m1_done), 32'((mdl_owner == 1) && (fin || abrt)));
    check("mdl_m0_rdata", m0_rdata, ((mdl_owner == 0) && abrt) ? ABORT : s_rdata);
    check("mdl_m1_rdata", m1_rdata, ((mdl_owner == 1) && abrt) ? ABORT : s_rdata);
    check("mdl_timeout_err", 32'(timeout_err), 32'(mdl_err));
    check("mdl_err_master",  32'(err_master),  32'(mdl_err_idx));
    // Outcome of the coming rising edge.
    if (rst_n) begin
      if (mdl_owner < 0) begin
        mdl_wait = 1;
        if (r0 && r1)  mdl_owner = mdl_last ? 0 : 1;
        else if (r0)   mdl_owner = 0;
        else if (r1)   mdl_owner = 1;
      end else if (!rq || fin || abrt) begin
        mdl_last = (mdl_owner == 1);
        if (abrt) begin
          mdl_err     = 1'b1;
          mdl_err_idx = (mdl_owner == 1);
        end
        mdl_owner = -1;
      end else begin
        mdl_wait++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_masters();
    m0_ren = 0; m0_wen = 0; m1_ren = 0; m1_wen = 0; s_done = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got running expected finished");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    step(); step();
    rst_n = 1'b1;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_terr",  32'(timeout_err), 32'd0);
    step();

    // Single m0 read, slave answers in the third GNT cycle.
    m0_addr = 32'h100; m0_ren = 1;
    step();
    check("rd_grant", 32'(grant), 32'b01);
    check("rd_saddr", s_addr, 32'h100);
    step(); step();
    s_done = 1; s_rdata = 32'h1234; #1;
    check("rd_m0_done",  32'(m0_done), 32'd1);
    check("rd_m0_rdata", m0_rdata, 32'h1234);
    check("rd_m1_done",  32'(m1_done), 32'd0);
    step(); idle_masters();
    check("rd_idle", 32'(grant), 32'd0);

    // Contention straight out of reset: m0, idle, m1, idle, m0.
    rst_n = 0; step(); rst_n = 1;
    m0_addr = 32'h40; m1_addr = 32'h80; m0_ren = 1; m1_ren = 1;
    step();
    check("rr_first", 32'(grant), 32'b01);
    s_done = 1;
    step(); s_done = 0;
    check("rr_gap", 32'(grant), 32'b00);
    step();
    check("rr_second", 32'(grant), 32'b10);
    check("rr_saddr", s_addr, 32'h80);
    s_done = 1;
    step(); s_done = 0;
    step();
    check("rr_third", 32'(grant), 32'b01);
    s_done = 1;
    step(); idle_masters();

    // m1 write mirrored onto the slave bus.
    m1_addr = 32'h2000; m1_wdata = 32'hA5A5A5A5; m1_wmask = 4'b0011; m1_wen = 1;
    step();
    check("wr_grant", 32'(grant), 32'b10);
    check("wr_saddr", s_addr, 32'h2000);
    check("wr_swdata", s_wdata, 32'hA5A5A5A5);
    check("wr_swmask", 32'(s_wmask), 32'b0011);
    check("wr_swen", 32'(s_wen), 32'd1);
    check("wr_sren", 32'(s_ren), 32'd0);
    s_done = 1;
    step(); idle_masters();

    // Simultaneous ren and wen from m0 pass through unchanged.
    m0_addr = 32'h300; m0_wdata = 32'h0F0F0F0F; m0_wmask = 4'hF; m0_ren = 1; m0_wen = 1;
    step();
    check("rw_sren", 32'(s_ren), 32'd1);
    check("rw_swen", 32'(s_wen), 32'd1);
    s_done = 1;
    step(); idle_masters();

    // Silent slave: m1 aborted on its 4th GNT cycle.
    m1_addr = 32'h500; m1_ren = 1; s_rdata = 32'h55;
    step(); step(); step();
    check("to_early", 32'(m1_done), 32'd0);
    step();
    check("to_m1_done",  32'(m1_done), 32'd1);
    check("to_m1_rdata", m1_rdata, 32'hDEADBEEF);
    check("to_m0_rdata", m0_rdata, 32'h55);
    step(); idle_masters();
    check("to_err",    32'(timeout_err), 32'd1);
    check("to_errm",   32'(err_master), 32'd1);
    s_done = 1; #1;
    check("to_late_m1", 32'(m1_done), 32'd0);
    check("to_late_gnt", 32'(grant), 32'd0);
    step(); s_done = 0;
    check("to_sticky", 32'(timeout_err), 32'd1);

    // m0 withdraws before s_done; last winner still moves to m0.
    m0_ren = 1;
    step(); step();
    m0_ren = 0;
    step();
    check("drop_idle", 32'(grant), 32'd0);
    m0_ren = 1; m1_ren = 1;
    step();
    check("drop_rr", 32'(grant), 32'b10);
    s_done = 1;
    step(); idle_masters();

    // Reset pulse in the middle of a GNT0 transaction.
    m0_addr = 32'h700; m0_ren = 1;
    step();
    check("rs_grant", 32'(grant), 32'b01);
    #2 rst_n = 0; #1;
    check("rs_sren",  32'(s_ren), 32'd0);
    check("rs_gnt0",  32'(grant), 32'd0);
    check("rs_done",  32'(m0_done), 32'd0);
    check("rs_terr",  32'(timeout_err), 32'd0);
    step(); rst_n = 1;
    step();
    check("rs_regrant", 32'(grant), 32'b01);
    s_done = 1;
    step(); idle_masters();
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
